rs232_uart: RTL and testbench
=============================

// Module: rs232_uart
// PURPOSE
//   Memory-mapped 8N1 UART peripheral on the CPU data bus (selected by address bit 29 at SoC level).
//   Word 0 = TX/RX data register; word 1 = status register.
//   Drives serial_out and samples serial_in at a fixed baud rate derived from clk.
// PARAMETERS
//   DIVISOR   434   clk cycles per serial bit (50 MHz / 115200); must be >= 4
// PORTS
//   clk          in   1   system clock; all logic on rising edge
//   reset        in   1   synchronous, active-high reset
//   serial_out   out  1   TX line, idle high
//   serial_in    in   1   RX line, asynchronous, idle high
//   address      in   1   register select: 0 = DATA, 1 = STATUS
//   writeenable  in   1   bus write strobe, one cycle per access
//   writedata    in   32  write data; only [7:0] used
//   readenable   in   1   bus read strobe, one cycle per access
//   readdata     out  32  registered read data
// BEHAVIOUR
//   Reset: serial_out=1, readdata=0, tx idle, rx idle, rx_valid=0, overrun=0.
//   Registers:
//     DATA   wr: if tx idle, load writedata[7:0] and start frame; if tx busy, write ignored.
//            rd: readdata={24'b0, rx_q}; clears rx_valid and overrun.
//     STATUS rd: readdata={29'b0, overrun, rx_valid, tx_busy}. Writes to STATUS ignored.
//   Read latency: readdata updates on the clk edge where readenable=1 (valid next cycle);
//     holds its value when readenable=0.
//   writeenable and readenable together: both take effect.
//   TX:
//     - States IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
//     - Each bit lasts exactly DIVISOR cycles.
//     - serial_out changes on the edge after the accepting write (start bit begins then).
//     - tx_busy=1 from the write edge through the end of the stop bit.
//     - Frame is 10*DIVISOR cycles; the next write is accepted on the first cycle tx_busy=0.
//   RX:
//     - serial_in passes through a 2-flop synchronizer before use.
//     - States IDLE -> START -> DATA -> STOP -> IDLE.
//     - IDLE: a low sample starts the bit counter.
//     - START: sample at DIVISOR/2; if high, false start -> IDLE.
//     - DATA: sample each bit DIVISOR cycles after the previous sample, LSB first.
//     - STOP: sample the stop bit.
//         stop=1: rx_q<=byte, rx_valid<=1; overrun<=1 if rx_valid was already 1
//           (new byte overwrites).
//         stop=0 (framing error): byte discarded, rx_valid/overrun unchanged.
//       Return to IDLE after the stop sample, so a back-to-back start bit is caught.
//   Simultaneous: a byte completes in the same cycle as a DATA read -> readdata returns the
//     old rx_q; new byte stored, rx_valid stays 1, overrun not set.
//   Reset mid-frame aborts both TX and RX immediately; serial_out returns to 1 next cycle.
//   Bit-period counters are sized by $clog2(DIVISOR) and wrap to 0 at DIVISOR-1.
// TESTING (DIVISOR=4)
//   1 reset held 2 cycles -> serial_out=1; STATUS read returns 0x0.
//   2 write 0xA5 to DATA -> serial_out = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles;
//     STATUS bit0=1 during the frame, 0 after 40 cycles.
//   3 write 0x11 while busy -> ignored; only the first byte is transmitted.
//   4 drive RX frame 0x3C at 4 cycles/bit -> STATUS=0x2; DATA read=0x3C, then STATUS=0x0.
//   5 two RX frames 0x01, 0x02 without reading -> STATUS=0x6; DATA read=0x02; then STATUS=0x0.
//   6 2-cycle low glitch on serial_in -> no byte; framed 0x55 with stop=0 -> rx_valid stays 0.

Source files
------------

// File: rtl/rs232_uart.sv
// rs232_uart: memory-mapped 8N1 UART with a DATA word and a STATUS word.
// Ports:
//   clk         - system clock, rising edge
//   reset       - synchronous active-high reset
//   serial_out  - TX line, idles high
//   serial_in   - RX line, asynchronous, idles high
//   address     - 0 = DATA, 1 = STATUS
//   writeenable - one-cycle write strobe (DATA starts a frame when TX idle)
//   writedata   - bus write data, only [7:0] used
//   readenable  - one-cycle read strobe
//   readdata    - registered read data, holds between reads
//   STATUS = {29'b0, overrun, rx_valid, tx_busy}
module rs232_uart #(
    parameter int DIVISOR = 434
) (
    input  logic        clk,
    input  logic        reset,
    output logic        serial_out,
    input  logic        serial_in,
    input  logic        address,
    input  logic        writeenable,
    input  logic [31:0] writedata,
    input  logic        readenable,
    output logic [31:0] readdata
);

    localparam int CW = $clog2(DIVISOR);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIVISOR / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } uart_state_e;

    // ------------------------------------------------------------
    // TX
    // ------------------------------------------------------------
    uart_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          tx_out_q, tx_out_d;
    logic          tx_busy;
    logic          tx_load;
    logic          tx_bit_end;

    assign tx_busy    = (tx_state_q != S_IDLE);
    assign tx_load    = writeenable & ~address & ~tx_busy;
    assign tx_bit_end = (tx_cnt_q == BIT_LAST);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
        tx_out_d   = tx_out_q;
        if (tx_busy) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        end
        unique case (tx_state_q)
            S_IDLE: begin
                tx_out_d = 1'b1;
                if (tx_load) begin
                    // Start bit goes out on the same edge that accepts the write.
                    tx_state_d = S_START;
                    tx_cnt_d   = '0;
                    tx_sh_d    = writedata[7:0];
                    tx_out_d   = 1'b0;
                end
            end
            S_START: begin
                if (tx_bit_end) begin
                    tx_state_d = S_DATA;
                    tx_idx_d   = 3'd0;
                    tx_out_d   = tx_sh_q[0];
                end
            end
            S_DATA: begin
                if (tx_bit_end) begin
                    if (tx_idx_q == 3'd7) begin
                        tx_state_d = S_STOP;
                        tx_out_d   = 1'b1;
                    end else begin
                        tx_idx_d = tx_idx_q + 3'd1;
                        tx_sh_d  = tx_sh_q >> 1;
                        tx_out_d = tx_sh_q[1];
                    end
                end
            end
            S_STOP: begin
                if (tx_bit_end) begin
                    tx_state_d = S_IDLE;
                    tx_out_d   = 1'b1;
                end
            end
            default: begin
                tx_state_d = S_IDLE;
                tx_out_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_sh_q    <= 8'h00;
            tx_out_q   <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_sh_q    <= tx_sh_d;
            tx_out_q   <= tx_out_d;
        end
    end

    assign serial_out = tx_out_q;

    // ------------------------------------------------------------
    // RX
    // ------------------------------------------------------------
    logic          sync1_q, sync2_q;
    uart_state_e   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_bit_end;
    logic          rx_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= serial_in;
            sync2_q <= sync1_q;
        end
    end

    assign rx_bit_end = (rx_cnt_q == BIT_LAST);

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        rx_done    = 1'b0;
        if (rx_state_q != S_IDLE) begin
            rx_cnt_d = rx_bit_end ? '0 : rx_cnt_q + 1'b1;
        end
        unique case (rx_state_q)
            S_IDLE: begin
                if (!sync2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
            end
            S_START: begin
                // Mid start bit: re-check the line to reject glitches.
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d = '0;
                    rx_idx_d = 3'd0;
                    rx_state_d = sync2_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_bit_end) begin
                    rx_sh_d = {sync2_q, rx_sh_q[7:1]};
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Leave at mid stop bit so a back-to-back start is seen.
                if (rx_bit_end) begin
                    rx_state_d = S_IDLE;
                    rx_done    = sync2_q;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_sh_q    <= 8'h00;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    // ------------------------------------------------------------
    // Bus registers
    // ------------------------------------------------------------
    logic [7:0]  rx_q, rx_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic [31:0] readdata_q, readdata_d;
    logic        rd_data;
    logic        unused_wdata;

    assign unused_wdata = ^writedata[31:8];
    assign rd_data      = readenable & ~address;

    always_comb begin
        rx_d       = rx_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        readdata_d = readdata_q;
        if (rd_data) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
        if (rx_done) begin
            rx_d       = rx_sh_q;
            rx_valid_d = 1'b1;
            // A byte landing on the reading edge replaces the one
            // being read, so it is not an overrun.
            if (!rd_data) begin
                overrun_d = overrun_q | rx_valid_q;
            end
        end
        if (readenable) begin
            if (address) begin
                readdata_d = {29'b0, overrun_q, rx_valid_q, tx_busy};
            end else begin
                readdata_d = {24'b0, rx_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_q       <= 8'h00;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            readdata_q <= 32'h0;
        end else begin
            rx_q       <= rx_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_rs232_uart.sv
// tb_rs232_uart: random and directed stimulus against a waveform-level
// model of the UART; outputs compared every cycle after reset.
module tb_rs232_uart;

    localparam int DIV  = 4;
    localparam int LOGN = 65536;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        serial_in = 1'b1;
    logic        address = 1'b0;
    logic        writeenable = 1'b0;
    logic        readenable = 1'b0;
    logic [31:0] writedata = 32'h0;
    logic        serial_out;
    logic [31:0] readdata;

    rs232_uart #(.DIVISOR(DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .serial_out  (serial_out),
        .serial_in   (serial_in),
        .address     (address),
        .writeenable (writeenable),
        .writedata   (writedata),
        .readenable  (readenable),
        .readdata    (readdata)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
                      name, act, exp, $time);
    endtask

    // Model: txq holds the expected line level for each coming cycle.
    bit          txq[$];
    bit          m_valid = 1'b0;
    bit          m_ovr = 1'b0;
    logic [7:0]  m_rxq = 8'h00;
    logic [31:0] exp_rd = 32'h0;
    int          cyc = 0;
    int          acc_cyc = -1;
    bit          chk_en = 1'b0;
    bit          chk_rd = 1'b0;
    bit          so_log[LOGN];

    always @(posedge clk) begin : model
        bit         popped;
        logic [9:0] frame;
        cyc++;
        if (reset) begin
            txq.delete();
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_rxq   = 8'h00;
            exp_rd  = 32'h0;
        end else begin
            popped = (txq.size() > 0);
            if (popped) void'(txq.pop_front());
            if (readenable) begin
                if (address) begin
                    exp_rd = {29'b0, m_ovr, m_valid, popped};
                end else begin
                    exp_rd  = {24'b0, m_rxq};
                    m_valid = 1'b0;
                    m_ovr   = 1'b0;
                end
            end
            if (writeenable && !address && !popped) begin
                acc_cyc = cyc;
                frame = {1'b1, writedata[7:0], 1'b0};
                for (int i = 0; i < 10; i++)
                    for (int j = 0; j < DIV; j++) txq.push_back(frame[i]);
            end
        end
    end

    always @(posedge clk) begin : compare
        bit exp_so;
        #1;
        if (chk_en) begin
            exp_so = (txq.size() > 0) ? txq[0] : 1'b1;
            if (cyc < LOGN) so_log[cyc] = serial_out;
            chk("serial_out", 32'(serial_out), 32'(exp_so));
            if (chk_rd) chk("readdata", readdata, exp_rd);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic a, input logic [7:0] d);
        @(negedge clk);
        address     = a;
        writedata   = {24'($urandom), d};
        writeenable = 1'b1;
        @(negedge clk);
        writeenable = 1'b0;
    endtask

    task automatic bus_read(input logic a);
        @(negedge clk);
        address    = a;
        readenable = 1'b1;
        @(negedge clk);
        readenable = 1'b0;
    endtask

    task automatic bus_rw(input logic a, input logic [7:0] d);
        @(negedge clk);
        address     = a;
        writedata   = {24'($urandom), d};
        writeenable = 1'b1;
        readenable  = 1'b1;
        @(negedge clk);
        writeenable = 1'b0;
        readenable  = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            serial_in = bits[i];
            repeat (DIV) @(negedge clk);
        end
        serial_in = 1'b1;
    endtask

    task automatic deliver(input logic [7:0] b, input bit stop);
        if (stop) begin
            m_ovr = m_ovr | m_valid;
            m_valid = 1'b1;
            m_rxq = b;
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input bit stop);
        rx_frame(b, stop);
        idle(6);
        deliver(b, stop);
    endtask

    initial begin : main
        bit         pat[10];
        int         a5_cyc;
        logic [3:0] seen;
        int         zeros;
        logic [7:0] ba, bb;
        logic [31:0] rd, st;
        bit         saw_old, saw_new;

        pat = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        chk_en = 1'b1;
        chk_rd = 1'b1;
        chk("reset serial_out", 32'(serial_out), 32'h1);
        chk("reset readdata", readdata, 32'h0);

        bus_read(1'b1);
        chk("T1 status", readdata, 32'h0);

        bus_write(1'b0, 8'hA5);
        a5_cyc = acc_cyc;
        bus_read(1'b1);
        chk("T2 busy", readdata, 32'h1);
        bus_write(1'b0, 8'h11);
        bus_read(1'b1);
        chk("T3 busy", readdata, 32'h1);
        idle(45);
        bus_read(1'b1);
        chk("T2 idle", readdata, 32'h0);
        chk("T2 pre-idle", 32'(so_log[a5_cyc-1]), 32'h1);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 4; j++) seen[j] = so_log[a5_cyc + 4*k + j];
            chk($sformatf("T2 bit%0d", k), 32'(seen), {28'h0, {4{pat[k]}}});
        end
        zeros = 0;
        for (int i = 40; i < 50; i++) if (!so_log[a5_cyc + i]) zeros++;
        chk("T3 no second frame", zeros, 0);

        rx_send(8'h3C, 1'b1);
        bus_read(1'b1);
        chk("T4 status", readdata, 32'h2);
        bus_read(1'b0);
        chk("T4 data", readdata, 32'h3C);
        bus_read(1'b1);
        chk("T4 cleared", readdata, 32'h0);

        rx_frame(8'h01, 1'b1);
        rx_frame(8'h02, 1'b1);
        idle(6);
        deliver(8'h01, 1'b1);
        deliver(8'h02, 1'b1);
        bus_read(1'b1);
        chk("T5 status", readdata, 32'h6);
        bus_read(1'b0);
        chk("T5 data", readdata, 32'h02);
        bus_read(1'b1);
        chk("T5 cleared", readdata, 32'h0);

        @(negedge clk);
        serial_in = 1'b0;
        idle(2);
        serial_in = 1'b1;
        idle(10);
        bus_read(1'b1);
        chk("T6 glitch", readdata, 32'h0);
        rx_send(8'h55, 1'b0);
        bus_read(1'b1);
        chk("T6 framing", readdata, 32'h0);

        // Sweep a DATA read across the completion of a second byte.
        saw_old = 1'b0;
        saw_new = 1'b0;
        for (int off = 36; off <= 44; off++) begin
            ba = 8'(off);
            bb = 8'(off + 128);
            rx_send(ba, 1'b1);
            chk_rd = 1'b0;
            fork
                rx_frame(bb, 1'b1);
                begin
                    repeat (off) @(negedge clk);
                    bus_read(1'b0);
                end
            join
            rd = readdata;
            idle(4);
            bus_read(1'b1);
            st = readdata;
            chk("T7 data is old or new",
                32'((rd == {24'h0, ba}) || (rd == {24'h0, bb})), 32'h1);
            if (rd == {24'h0, bb}) begin
                saw_new = 1'b1;
                chk("T7 status after late read", st, 32'h0);
            end else begin
                saw_old = 1'b1;
                chk("T7 status after early read", st, 32'h2);
            end
            bus_read(1'b0);
            chk("T7 final data", readdata, {24'h0, bb});
            m_rxq   = bb;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            exp_rd  = {24'h0, bb};
            chk_rd  = 1'b1;
        end
        chk("T7 saw old byte", 32'(saw_old), 32'h1);
        chk("T7 saw new byte", 32'(saw_new), 32'h1);

        // Reset part-way through a TX frame and an RX frame.
        bus_write(1'b0, 8'h5A);
        idle(10);
        serial_in = 1'b0;
        idle(4);
        serial_in = 1'b1;
        idle(4);
        serial_in = 1'b0;
        idle(2);
        reset = 1'b1;
        serial_in = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("T8 serial_out", 32'(serial_out), 32'h1);
        chk("T8 readdata", readdata, 32'h0);
        idle(60);
        bus_read(1'b1);
        chk("T8 status", readdata, 32'h0);

        rx_send(8'h96, 1'b1);
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0: bus_write(1'($urandom), 8'($urandom));
                1: bus_read(1'b1);
                2: bus_read(1'b0);
                3: rx_send(8'($urandom), $urandom_range(0, 5) != 0);
                4: idle($urandom_range(1, 30));
                default: bus_rw(1'($urandom), 8'($urandom));
            endcase
        end
        idle(50);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
